// File: rtl/mux3_rr_arbiter_if.sv
// Bundle of requester-side and shared-slave-side signals around the 3:1 round-robin arbiter.
// The arbiter connects through the slave modport; the requesters/bus model use the master modport.
interface mux3_rr_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [2:0]       req;
  logic [2:0]       req_lock;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic             bus_ready;
  logic             bus_valid;
  logic [WIDTH-1:0] bus_data;
  logic [1:0]       sel;
  logic [2:0]       gnt;
  logic [2:0]       ack;

  modport slave (
    input  req, req_lock, d0, d1, d2, bus_ready,
    output bus_valid, bus_data, sel, gnt, ack
  );

  modport master (
    output req, req_lock, d0, d1, d2, bus_ready,
    input  bus_valid, bus_data, sel, gnt, ack
  );
endinterface

// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter sharing one downstream port among three requesters, with
// per-requester burst lock bounded to HOLD_MAX consecutive beats while others wait.
module mux3_rr_arbiter #(
  parameter int WIDTH    = 32,
  parameter int HOLD_MAX = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  mux3_rr_arbiter_if.slave      bus
);

  localparam int HW = $clog2(HOLD_MAX) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
  localparam logic [HW-1:0] HOLD_SAT  = {HW{1'b1}};

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic [2:0]    gnt_q, gnt_d;
  logic [1:0]    last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;

  logic [1:0]    pick;
  logic          owner_req;
  logic          owner_lock;
  logic          others;
  logic          valid;

  // First requester scanning from+1, from+2, from (mod 3).
  function automatic logic [1:0] arb(input logic [1:0] from, input logic [2:0] r);
    logic [1:0] res;
    logic       found;
    logic [1:0] idx;
    res   = 2'd0;
    found = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      idx = 2'((int'(from) + k) % 3);
      if (!found && r[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] s);
    return 3'b001 << s;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      gnt_q   <= 3'b000;
      last_q  <= 2'd2;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    hold_d     = hold_q;
    pick       = 2'd0;
    owner_req  = bus.req[sel_q];
    owner_lock = bus.req_lock[sel_q];
    others     = |(bus.req & ~gnt_q);
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          pick    = arb(last_q, bus.req);
          state_d = BUSY;
          sel_d   = pick;
          gnt_d   = onehot(pick);
          hold_d  = '0;
        end
      end
      BUSY: begin
        if (bus.bus_ready) begin
          // A locked owner keeps the port until it has used its quota while someone else waits.
          if (owner_lock && owner_req && (hold_q < HOLD_LAST || !others)) begin
            if (hold_q != HOLD_SAT) hold_d = hold_q + 1'b1;
          end else begin
            last_d = sel_q;
            hold_d = '0;
            if (|bus.req) begin
              pick  = arb(sel_q, bus.req);
              sel_d = pick;
              gnt_d = onehot(pick);
            end else begin
              state_d = IDLE;
              sel_d   = 2'd0;
              gnt_d   = 3'b000;
            end
          end
        end else if (!owner_req) begin
          // Abandoned before completion: no ack and the priority pointer stays put.
          state_d = IDLE;
          sel_d   = 2'd0;
          gnt_d   = 3'b000;
          hold_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid         = (state_q == BUSY);
    bus.bus_valid = valid;
    bus.sel       = sel_q;
    bus.gnt       = gnt_q;
    bus.ack       = gnt_q & {3{valid & bus.bus_ready}};
    case (sel_q)
      2'd1:    bus.bus_data = bus.d1;
      2'd2:    bus.bus_data = bus.d2;
      default: bus.bus_data = bus.d0;
    endcase
  end

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Directed and constrained-random bench for mux3_rr_arbiter with hand-computed expectations.
module tb_mux3_rr_arbiter;
  localparam int W  = 32;
  localparam int HM = 8;
  localparam logic [W-1:0] D0 = 32'hA0A0_0000;
  localparam logic [W-1:0] D1 = 32'hB1B1_1111;
  localparam logic [W-1:0] D2 = 32'hC2C2_2222;

  logic clk = 1'b0;
  logic reset;
  int   vec  = 0;
  int   miss = 0;

  mux3_rr_arbiter_if #(.WIDTH(W)) bus ();

  mux3_rr_arbiter #(.WIDTH(W), .HOLD_MAX(HM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    bus.req = 3'b000; bus.req_lock = 3'b000; bus.bus_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.req = 3'b111; bus.req_lock = 3'b000; bus.bus_ready = 1'b1;
    tick();
    vec++; if (bus.bus_valid !== 1'b0) begin miss++; $display("FAIL reset_valid got %b exp 0", bus.bus_valid); end
    vec++; if (bus.gnt !== 3'b000) begin miss++; $display("FAIL reset_gnt got %b exp 000", bus.gnt); end
    vec++; if (bus.sel !== 2'b00) begin miss++; $display("FAIL reset_sel got %b exp 00", bus.sel); end
    vec++; if (bus.ack !== 3'b000) begin miss++; $display("FAIL reset_ack got %b exp 000", bus.ack); end
    vec++; if (bus.bus_data !== D0) begin miss++; $display("FAIL reset_data got %h exp %h", bus.bus_data, D0); end
    bus.req = 3'b000;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_round_robin;
    logic [2:0]   eg [4];
    logic [1:0]   es [4];
    logic [W-1:0] ed [4];
    eg = '{3'b001, 3'b010, 3'b100, 3'b001};
    es = '{2'd0, 2'd1, 2'd2, 2'd0};
    ed = '{D0, D1, D2, D0};
    do_reset();
    bus.req = 3'b111; bus.req_lock = 3'b000; bus.bus_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      vec++; if (bus.gnt !== eg[k]) begin miss++; $display("FAIL rr_gnt[%0d] got %b exp %b", k, bus.gnt, eg[k]); end
      vec++; if (bus.sel !== es[k]) begin miss++; $display("FAIL rr_sel[%0d] got %b exp %b", k, bus.sel, es[k]); end
      vec++; if (bus.ack !== eg[k]) begin miss++; $display("FAIL rr_ack[%0d] got %b exp %b", k, bus.ack, eg[k]); end
      vec++; if (bus.bus_data !== ed[k]) begin miss++; $display("FAIL rr_data[%0d] got %h exp %h", k, bus.bus_data, ed[k]); end
    end
    bus.req = 3'b000;
    tick();
    vec++; if (bus.bus_valid !== 1'b0) begin miss++; $display("FAIL rr_idle got %b exp 0", bus.bus_valid); end
  endtask

  task automatic test_stall;
    do_reset();
    bus.bus_ready = 1'b0; bus.req = 3'b010;
    for (int k = 0; k < 4; k++) begin
      tick();
      vec++; if (bus.bus_valid !== 1'b1) begin miss++; $display("FAIL stall_valid[%0d] got %b exp 1", k, bus.bus_valid); end
      vec++; if (bus.sel !== 2'd1) begin miss++; $display("FAIL stall_sel[%0d] got %b exp 01", k, bus.sel); end
      vec++; if (bus.bus_data !== D1) begin miss++; $display("FAIL stall_data[%0d] got %h exp %h", k, bus.bus_data, D1); end
      vec++; if (bus.ack !== 3'b000) begin miss++; $display("FAIL stall_ack[%0d] got %b exp 000", k, bus.ack); end
    end
    bus.bus_ready = 1'b1;
    #1;
    vec++; if (bus.ack !== 3'b010) begin miss++; $display("FAIL stall_ack_pulse got %b exp 010", bus.ack); end
    bus.req = 3'b000;
    tick();
    vec++; if (bus.gnt !== 3'b000) begin miss++; $display("FAIL stall_release_gnt got %b exp 000", bus.gnt); end
    vec++; if (bus.ack !== 3'b000) begin miss++; $display("FAIL stall_after_ack got %b exp 000", bus.ack); end
  endtask

  task automatic test_lock_hold;
    int cnt;
    int bad;
    do_reset();
    bus.req = 3'b011; bus.req_lock = 3'b001; bus.bus_ready = 1'b1;
    tick();
    cnt = 0;
    while (bus.gnt === 3'b001 && cnt < 20) begin
      cnt++;
      tick();
    end
    vec++; if (cnt != HM) begin miss++; $display("FAIL lock_beats got %0d exp %0d", cnt, HM); end
    vec++; if (bus.gnt !== 3'b010) begin miss++; $display("FAIL lock_rotate_gnt got %b exp 010", bus.gnt); end
    // Requester 1 leaves; 0 returns and keeps the port with nobody else waiting.
    bus.req = 3'b001;
    tick();
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.gnt !== 3'b001 || bus.ack !== 3'b001) bad++;
      tick();
    end
    vec++; if (bad != 0) begin miss++; $display("FAIL lock_forever got %0d bad cycles exp 0", bad); end
    bus.req = 3'b000; bus.req_lock = 3'b000;
    tick();
  endtask

  task automatic test_abandon;
    do_reset();
    bus.req = 3'b001; bus.bus_ready = 1'b1;
    tick();
    bus.req = 3'b000;
    tick();
    bus.req = 3'b100; bus.bus_ready = 1'b0;
    tick();
    vec++; if (bus.gnt !== 3'b100) begin miss++; $display("FAIL abandon_owner got %b exp 100", bus.gnt); end
    bus.req = 3'b000;
    #1;
    vec++; if (bus.ack !== 3'b000) begin miss++; $display("FAIL abandon_ack got %b exp 000", bus.ack); end
    tick();
    vec++; if (bus.bus_valid !== 1'b0) begin miss++; $display("FAIL abandon_valid got %b exp 0", bus.bus_valid); end
    vec++; if (bus.gnt !== 3'b000) begin miss++; $display("FAIL abandon_gnt got %b exp 000", bus.gnt); end
    bus.req = 3'b111;
    tick();
    vec++; if (bus.gnt !== 3'b010) begin miss++; $display("FAIL abandon_pointer got %b exp 010", bus.gnt); end
    bus.req = 3'b000;
    tick();
  endtask

  task automatic test_reset_mid_burst;
    do_reset();
    bus.req = 3'b010; bus.req_lock = 3'b010; bus.bus_ready = 1'b1;
    tick(); tick();
    vec++; if (bus.gnt !== 3'b010) begin miss++; $display("FAIL burst_owner got %b exp 010", bus.gnt); end
    reset = 1'b1;
    tick();
    vec++; if (bus.gnt !== 3'b000) begin miss++; $display("FAIL midrst_gnt got %b exp 000", bus.gnt); end
    vec++; if (bus.sel !== 2'b00) begin miss++; $display("FAIL midrst_sel got %b exp 00", bus.sel); end
    vec++; if (bus.bus_valid !== 1'b0) begin miss++; $display("FAIL midrst_valid got %b exp 0", bus.bus_valid); end
    reset = 1'b0; bus.req = 3'b111; bus.req_lock = 3'b000;
    tick();
    vec++; if (bus.gnt !== 3'b001) begin miss++; $display("FAIL midrst_first got %b exp 001", bus.gnt); end
    bus.req = 3'b000;
    tick();
  endtask

  task automatic test_random;
    int wt [3];
    int mx [3];
    int bad;
    logic beat;
    do_reset();
    wt = '{0, 0, 0};
    mx = '{0, 0, 0};
    bad = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      beat = bus.bus_valid & bus.bus_ready;
      if (!(bus.gnt inside {3'b000, 3'b001, 3'b010, 3'b100})) bad++;
      if (bus.sel === 2'b11) bad++;
      if (bus.ack !== (bus.gnt & {3{beat}})) bad++;
      if (bus.bus_valid !== (bus.gnt != 3'b000)) bad++;
      if (bus.gnt != 3'b000 && bus.gnt !== (3'b001 << bus.sel)) bad++;
      for (int i = 0; i < 3; i++) begin
        if (bus.req[i] && !bus.gnt[i]) begin
          if (beat) wt[i]++;
        end else begin
          wt[i] = 0;
        end
        if (wt[i] > mx[i]) mx[i] = wt[i];
      end
      for (int i = 0; i < 3; i++) begin
        if (!bus.req[i]) bus.req[i] = ($urandom_range(0, 2) == 0);
        else if (bus.ack[i]) bus.req[i] = $urandom_range(0, 1) == 1;
      end
      bus.req_lock  = 3'($urandom_range(0, 7));
      bus.bus_ready = ($urandom_range(0, 3) != 0);
    end
    vec++; if (bad != 0) begin miss++; $display("FAIL rand_invariants got %0d violations exp 0", bad); end
    for (int i = 0; i < 3; i++) begin
      vec++; if (mx[i] > 2*HM + 2) begin miss++; $display("FAIL rand_wait[%0d] got %0d beats exp <= %0d", i, mx[i], 2*HM + 2); end
    end
    bus.req = 3'b000; bus.req_lock = 3'b000;
  endtask

  initial begin
    reset = 1'b1;
    bus.req = 3'b000; bus.req_lock = 3'b000; bus.bus_ready = 1'b0;
    bus.d0 = D0; bus.d1 = D1; bus.d2 = D2;
    test_reset();
    test_round_robin();
    test_stall();
    test_lock_hold();
    test_abandon();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
